// File: rtl/rst_seq_pkg.sv
// Shared types for the reset release sequencer: FSM state encoding and
// the width rule for the hold/timeout counters.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT   = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2,
    FAULT    = 2'd3
  } rst_seq_state_e;

  // Wide enough to reach the larger of the two terminal counts without wrapping.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned timeout_cycles);
    int unsigned max_cycles;
    max_cycles = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
    return $clog2(max_cycles) + 1;
  endfunction

endpackage

// File: rtl/rst_release_sequencer_if.sv
// Domain-facing and software-facing signals of the reset release sequencer,
// grouped so the sequencer (master) and the domains/software (slave) share one bundle.
interface rst_release_sequencer_if #(
  parameter int unsigned NUM_DOMAINS = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_DOMAINS);

  // Handshake: a rising domain_rst_no[i] offers release to domain i; domain_ack_i[i]
  // is a level "ready" that is only sampled while i is the index being waited on.
  // sw_rst_req_i is a single-cycle pulse, honoured only once the sequence has ended.
  logic                   sw_rst_req_i;
  logic [NUM_DOMAINS-1:0] domain_ack_i;
  logic [NUM_DOMAINS-1:0] domain_rst_no;
  logic                   seq_busy_o;
  logic                   seq_done_o;
  logic                   timeout_o;
  logic [IDX_W-1:0]       fail_idx_o;

  modport master (
    input  sw_rst_req_i,
    input  domain_ack_i,
    output domain_rst_no,
    output seq_busy_o,
    output seq_done_o,
    output timeout_o,
    output fail_idx_o
  );

  modport slave (
    output sw_rst_req_i,
    output domain_ack_i,
    input  domain_rst_no,
    input  seq_busy_o,
    input  seq_done_o,
    input  timeout_o,
    input  fail_idx_o
  );

endinterface

// File: rtl/rst_seq_timer.sv
// Loadable saturating up-counter with synchronous clear; tc_o flags that the
// count sits at the terminal value.
module rst_seq_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] term_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Clear beats load beats count; counting stops at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q < term_val_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_val_i);

endmodule

// File: rtl/rst_release_sequencer.sv
// Holds all downstream domains in reset, then releases them one by one in index
// order on each domain's ack. Optional ack watchdog: define RST_SEQ_TIMEOUT_EN.
module rst_release_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  rst_release_sequencer_if.master bus,
  output rst_seq_state_e          state_o
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned IDX_W = $clog2(NUM_DOMAINS);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  rst_seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   hold_tc;
  logic                   ack_cur;
  logic                   restart;

  assign ack_cur = bus.domain_ack_i[idx_q];

  rst_seq_timer #(.WIDTH(CNT_W)) u_hold_timer (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .clr_i      (state_q != ASSERT),
    .en_i       (state_q == ASSERT),
    .load_i     (1'b0),
    .load_val_i ('0),
    .term_val_i (HOLD_TERM),
    .tc_o       (hold_tc)
  );

`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  logic             tmo_tc;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;

  // Restarts from zero whenever a new index becomes the one being waited on.
  rst_seq_timer #(.WIDTH(CNT_W)) u_tmo_timer (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .clr_i      ((state_q != WAIT_ACK) || ack_cur),
    .en_i       (state_q == WAIT_ACK),
    .load_i     (1'b0),
    .load_val_i ('0),
    .term_val_i (TMO_TERM),
    .tc_o       (tmo_tc)
  );
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    busy_d  = busy_q;
    done_d  = done_q;
    restart = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
    timeout_d  = timeout_q;
    fail_idx_d = fail_idx_q;
`endif
    case (state_q)
      ASSERT: begin
        if (hold_tc) begin
          state_d    = WAIT_ACK;
          idx_d      = '0;
          rst_n_d[0] = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (ack_cur) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d          = idx_q + 1'b1;
            rst_n_d[idx_d] = 1'b1;
          end
        end
`ifdef RST_SEQ_TIMEOUT_EN
        // An ack on the expiry cycle takes the branch above, so it wins.
        else if (tmo_tc) begin
          state_d    = FAULT;
          rst_n_d    = '0;
          busy_d     = 1'b0;
          done_d     = 1'b0;
          timeout_d  = 1'b1;
          fail_idx_d = idx_q;
        end
`endif
      end
      DONE, FAULT: begin
        restart = bus.sw_rst_req_i;
      end
      default: begin
        restart = 1'b1;
      end
    endcase

    if (restart) begin
      state_d = ASSERT;
      idx_d   = '0;
      rst_n_d = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q <= ASSERT;
      idx_q   <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef RST_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      timeout_q  <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      timeout_q  <= timeout_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign bus.timeout_o  = timeout_q;
  assign bus.fail_idx_o = fail_idx_q;
`else
  assign bus.timeout_o  = 1'b0;
  assign bus.fail_idx_o = '0;
`endif

  assign bus.domain_rst_no = rst_n_q;
  assign bus.seq_busy_o    = busy_q;
  assign bus.seq_done_o    = done_q;
  assign state_o           = state_q;

endmodule

// File: doc/rst_release_sequencer.md
# rst_release_sequencer

Controller that sequences reset release across `NUM_DOMAINS` downstream reset domains. It sits directly after the reset deassertion synchronizer and consumes its synchronized, active-low system reset. It holds every domain in reset for a fixed interval, then releases the domains one at a time in index order, waiting for each domain's ready acknowledge before releasing the next. It supports software-requested re-sequencing and an optional acknowledge-timeout watchdog.

## Interface
- `NUM_DOMAINS`, 4: number of sequenced domains (≥2).
- `HOLD_CYCLES`, 16: cycles all domains are held in reset before domain 0 is released (≥1).
- `TIMEOUT_CYCLES`, 1024: maximum wait for one domain's ack, in cycles (≥1). Only used with `RST_SEQ_TIMEOUT_EN`.
- `clk` in 1: single clock.
- `rst_ni` in 1: reset, synchronous, active-low (driven from synchronizer output).
- `sw_rst_req_i` in 1: single-cycle request to re-run the full sequence.
- `domain_ack_i` in `NUM_DOMAINS`: per-domain ready, level-sensitive.
- `domain_rst_no` out `NUM_DOMAINS`: per-domain reset, active-low (0 = held in reset).
- `seq_busy_o` out 1: sequence in progress.
- `seq_done_o` out 1: all domains released and acknowledged.
- `timeout_o` out 1: ack timeout fault, sticky.
- `fail_idx_o` out `$clog2(NUM_DOMAINS)`: index of the domain that timed out.

## Operation
- States:
  - `ASSERT`: all resets held; hold counter runs.
  - `WAIT_ACK`: domains 0..idx released; waiting on `domain_ack_i[idx]`.
  - `DONE`
  - `FAULT`: exists only with the macro.
- Reset state while `rst_ni`=0 at an edge:
  - state `ASSERT`, hold counter 0, idx 0.
  - `domain_rst_no`=0 (all bits), `seq_busy_o`=1, `seq_done_o`=0, `timeout_o`=0, `fail_idx_o`=0.
- `ASSERT`: counter increments each cycle. At counter == `HOLD_CYCLES`-1 → `WAIT_ACK`, idx=0, `domain_rst_no[0]`←1.
- `WAIT_ACK`, when `domain_ack_i[idx]`=1 is sampled:
  - if idx < `NUM_DOMAINS`-1: idx+1, and `domain_rst_no[idx+1]`←1 on the same edge.
  - otherwise → `DONE`: `seq_busy_o`←0, `seq_done_o`←1.
- Acks from domains not yet being waited on are ignored. Already-released domains stay released.
- `DONE`: all `domain_rst_no`=1. A later drop of any ack is ignored.
- `sw_rst_req_i`:
  - In `DONE` or `FAULT`, next edge: all `domain_rst_no`←0, `seq_done_o`←0, `timeout_o`←0, `seq_busy_o`←1, counter←0, idx←0, → `ASSERT`.
  - Ignored in `ASSERT` and `WAIT_ACK`.
- Releases are strictly monotonic in index. Two domains never release on the same edge.

## Timing
- All outputs are registered.
- `domain_rst_no[0]` rises on the `HOLD_CYCLES`-th rising edge at which `rst_ni`=1.
- Ack to next release: 1 cycle (ack sampled on edge n → next reset bit high after edge n).
- Last ack to `seq_done_o`: 1 cycle.
- `rst_ni`=0 mid-sequence (any state) → reset values after that edge, with no partial-release hold-over.
- `sw_rst_req_i` to all resets asserted: 1 cycle.
- Hold and timeout counters are `$clog2(max(HOLD_CYCLES, TIMEOUT_CYCLES))+1` bits, unsigned, with no wrap: they saturate at their terminal value.

## Configuration
- `RST_SEQ_TIMEOUT_EN` defined:
  - In `WAIT_ACK`, the timeout counter clears on entry to each idx and increments each cycle without ack.
  - At counter == `TIMEOUT_CYCLES`-1 with no ack → `FAULT`: all `domain_rst_no`←0, `timeout_o`←1, `fail_idx_o`←idx, `seq_busy_o`←0, `seq_done_o`=0.
  - Ack and expiry on the same cycle: ack wins.
  - `FAULT` exits only via `sw_rst_req_i` or `rst_ni`.
- Not defined: no `FAULT` state and no timeout counter. `WAIT_ACK` waits indefinitely; `timeout_o` and `fail_idx_o` are tied to 0.

## Structure
- Package `rst_seq_pkg` holds the state enum (`ASSERT`, `WAIT_ACK`, `DONE`, `FAULT`) and the counter-width constant function.
- Sub-module `rst_seq_timer`: loadable saturating up-counter with clear and terminal-count flag, used for both the hold and timeout counts.

## Test plan
Parameters: `NUM_DOMAINS`=4, `HOLD_CYCLES`=16, `TIMEOUT_CYCLES`=64.
- Reset release, acks tied high → `domain_rst_no` goes 0001, 0011, 0111, 1111 on edges 16, 17, 18, 19; `seq_done_o`=1 at edge 20.
- Ack 2 delayed 10 cycles after release → bit 3 stays 0 until 1 cycle after ack 2; acks 3 given early have no effect.
- `rst_ni` low during `WAIT_ACK` idx=2 → next edge `domain_rst_no`=0000, `seq_busy_o`=1; after release, full 16-cycle hold is repeated.
- In `DONE`, pulse `sw_rst_req_i` → `domain_rst_no`=0000 the next cycle, then the full sequence reruns. A pulse during `ASSERT` is ignored.
- With macro, ack 1 never asserted → after 64 cycles `timeout_o`=1, `fail_idx_o`=1, `domain_rst_no`=0000. `sw_rst_req_i` clears the fault and restarts the sequence.
- With macro, ack 1 arrives on the expiry cycle → no fault, sequence continues.
